// File: rtl/id_hazard_unit_if.sv
// ID-stage hazard unit bundle: decoded ID fields and compare flags in,
// stall/flush/forward controls and performance counters out.
interface id_hazard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic              id_branch;
   logic              id_bne;
   logic [REG_AW-1:0] id_dest;
   logic              id_regwrite;
   logic              id_memread;
   logic              rf_eq;
   logic              fwd_eq;
   logic              stall;
   logic              flush_ifid;
   logic              branch_taken;
   logic              fwd_rs_sel;
   logic              fwd_rt_sel;
   logic [CNT_W-1:0]  stall_cycles;
   logic [CNT_W-1:0]  branch_flushes;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
      output id_branch, id_bne, id_dest, id_regwrite, id_memread,
      output rf_eq, fwd_eq,
      input  stall, flush_ifid, branch_taken, fwd_rs_sel, fwd_rt_sel,
      input  stall_cycles, branch_flushes
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
      input  id_branch, id_bne, id_dest, id_regwrite, id_memread,
      input  rf_eq, fwd_eq,
      output stall, flush_ifid, branch_taken, fwd_rs_sel, fwd_rt_sel,
      output stall_cycles, branch_flushes
   );
endinterface

// File: rtl/id_hazard_unit.sv
// ID-stage hazard detection, branch-comparator forwarding select and
// beq/bne resolution, with saturating stall/flush counters.
module id_hazard_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic        clk,
   input logic        rst_n,
   id_hazard_if.slave hz
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dest;
      logic              regwrite;
      logic              memread;
   } slot_t;

   // WB needs no shadow: the RF writes before it reads, so WB never hazards.
   slot_t ex_q;
   slot_t mem_q;

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   logic [1:0] rs_hz;
   logic [1:0] rt_hz;
   logic       stall_raw;
   logic       rs_fwd;
   logic       rt_fwd;
   logic       eq_used;
   logic       taken;

   // {stall, fwd} for one source; EX outranks MEM as the newer producer.
   function automatic logic [1:0] src_hz(
      input logic              live,
      input logic [REG_AW-1:0] s,
      input slot_t             ex,
      input slot_t             mem,
      input logic              br
   );
      logic ex_hit;
      logic mem_hit;
      logic st;
      logic fw;
      ex_hit  = live & ex.valid & ex.regwrite & (ex.dest == s);
      mem_hit = live & mem.valid & mem.regwrite & (mem.dest == s);
      st = (ex_hit & (br | ex.memread))
         | (~ex_hit & mem_hit & br & mem.memread);
      fw = ~ex_hit & mem_hit & br & ~mem.memread;
      return {st, fw};
   endfunction

   always_comb begin
      rs_hz = src_hz(hz.id_valid & hz.id_uses_rs & (hz.id_rs != '0),
                     hz.id_rs, ex_q, mem_q, hz.id_branch);
      rt_hz = src_hz(hz.id_valid & hz.id_uses_rt & (hz.id_rt != '0),
                     hz.id_rt, ex_q, mem_q, hz.id_branch);
      stall_raw = rs_hz[1] | rt_hz[1];
      rs_fwd    = rst_n & ~stall_raw & rs_hz[0];
      rt_fwd    = rst_n & ~stall_raw & rt_hz[0];
      eq_used   = (rs_fwd | rt_fwd) ? hz.fwd_eq : hz.rf_eq;
      taken     = rst_n & hz.id_valid & hz.id_branch & ~stall_raw
                & (eq_used ^ hz.id_bne);
   end

   assign hz.stall          = rst_n & stall_raw;
   assign hz.fwd_rs_sel     = rs_fwd;
   assign hz.fwd_rt_sel     = rt_fwd;
   assign hz.branch_taken   = taken;
   assign hz.flush_ifid     = taken;
   assign hz.stall_cycles   = stall_cnt_q;
   assign hz.branch_flushes = flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
      end else begin
         mem_q          <= ex_q;
         ex_q.valid     <= hz.id_valid & ~stall_raw;
         ex_q.dest      <= hz.id_dest;
         ex_q.regwrite  <= hz.id_regwrite;
         ex_q.memread   <= hz.id_memread;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_raw && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (taken && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit; a 4-bit-counter twin sees the same
// stimulus so counter saturation is reached in a few dozen cycles.
module tb_id_hazard_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   id_hazard_if #(.REG_AW(5), .CNT_W(16)) hif ();
   id_hazard_if #(.REG_AW(5), .CNT_W(4))  sif ();

   assign sif.id_valid    = hif.id_valid;
   assign sif.id_rs       = hif.id_rs;
   assign sif.id_rt       = hif.id_rt;
   assign sif.id_uses_rs  = hif.id_uses_rs;
   assign sif.id_uses_rt  = hif.id_uses_rt;
   assign sif.id_branch   = hif.id_branch;
   assign sif.id_bne      = hif.id_bne;
   assign sif.id_dest     = hif.id_dest;
   assign sif.id_regwrite = hif.id_regwrite;
   assign sif.id_memread  = hif.id_memread;
   assign sif.rf_eq       = hif.rf_eq;
   assign sif.fwd_eq      = hif.fwd_eq;

   id_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif.slave)
   );

   id_hazard_unit #(.REG_AW(5), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (sif.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // valid, rs, rt, uses_rs, uses_rt, branch, bne, dest, regwrite,
   // memread, rf_eq, fwd_eq
   task automatic set_id(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urs,
                         input logic urt, input logic br, input logic bne,
                         input logic [4:0] dst, input logic rw,
                         input logic mr, input logic rfe, input logic fwe);
      hif.id_valid    = v;
      hif.id_rs       = rs;
      hif.id_rt       = rt;
      hif.id_uses_rs  = urs;
      hif.id_uses_rt  = urt;
      hif.id_branch   = br;
      hif.id_bne      = bne;
      hif.id_dest     = dst;
      hif.id_regwrite = rw;
      hif.id_memread  = mr;
      hif.rf_eq       = rfe;
      hif.fwd_eq      = fwe;
      #1;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      nop();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      nop();
      #2;
      chk("rst_stall", hif.stall, 0);
      chk("rst_flush", hif.flush_ifid, 0);
      chk("rst_scnt", hif.stall_cycles, 0);
      chk("rst_fcnt", hif.branch_flushes, 0);
      tick();
      rst_n = 1'b1;
      #1;

      // lw $8 then add $9,$8,$1
      set_id(1, 1, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0);
      chk("lu_lw_nostall", hif.stall, 0);
      tick();
      set_id(1, 8, 1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
      chk("lu_stall", hif.stall, 1);
      chk("lu_flush", hif.flush_ifid, 0);
      chk("lu_fwd", {hif.fwd_rs_sel, hif.fwd_rt_sel}, 0);
      tick();
      chk("lu_release", hif.stall, 0);
      chk("lu_scnt", hif.stall_cycles, 1);
      tick();
      chk("lu_scnt_hold", hif.stall_cycles, 1);

      // add $9 then beq $9,$0
      pulse_reset();
      set_id(1, 1, 2, 1, 1, 0, 0, 9, 1, 0, 0, 0);
      tick();
      set_id(1, 9, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
      chk("br_ex_stall", hif.stall, 1);
      chk("br_ex_taken", hif.branch_taken, 0);
      tick();
      chk("br_mem_stall", hif.stall, 0);
      chk("br_fwd_rs", hif.fwd_rs_sel, 1);
      chk("br_fwd_rt", hif.fwd_rt_sel, 0);
      chk("br_taken", hif.branch_taken, 1);
      chk("br_flush", hif.flush_ifid, 1);
      tick();
      nop();
      chk("br_fcnt", hif.branch_flushes, 1);
      chk("br_scnt", hif.stall_cycles, 1);

      // lw $10 then beq $10,$11
      pulse_reset();
      set_id(1, 1, 0, 1, 0, 0, 0, 10, 1, 1, 0, 0);
      tick();
      set_id(1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 1, 0);
      chk("lb_stall1", hif.stall, 1);
      tick();
      chk("lb_stall2", hif.stall, 1);
      chk("lb_taken2", hif.branch_taken, 0);
      tick();
      chk("lb_stall3", hif.stall, 0);
      chk("lb_fwd3", {hif.fwd_rs_sel, hif.fwd_rt_sel}, 0);
      chk("lb_taken3", hif.branch_taken, 1);
      tick();
      nop();
      chk("lb_scnt", hif.stall_cycles, 2);

      // addi $0 then beq $0,$0, then bne with equal operands
      pulse_reset();
      set_id(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      set_id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
      chk("r0_stall", hif.stall, 0);
      chk("r0_fwd", {hif.fwd_rs_sel, hif.fwd_rt_sel}, 0);
      chk("r0_taken", hif.branch_taken, 1);
      tick();
      set_id(1, 3, 4, 1, 1, 1, 1, 0, 0, 0, 1, 0);
      chk("bne_eq_taken", hif.branch_taken, 0);
      chk("bne_eq_flush", hif.flush_ifid, 0);
      set_id(1, 3, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      chk("bne_ne_taken", hif.branch_taken, 1);

      // add $7, bubble, then beq $6,$7: rt forwarded, fwd_eq decides
      pulse_reset();
      set_id(1, 1, 2, 1, 1, 0, 0, 7, 1, 0, 0, 0);
      tick();
      nop();
      tick();
      set_id(1, 6, 7, 1, 1, 1, 0, 0, 0, 0, 1, 0);
      chk("rtf_stall", hif.stall, 0);
      chk("rtf_sel", {hif.fwd_rs_sel, hif.fwd_rt_sel}, 2'b01);
      chk("rtf_taken", hif.branch_taken, 0);
      set_id(1, 6, 7, 1, 0, 1, 0, 0, 0, 0, 1, 0);
      chk("rtf_unused", hif.fwd_rt_sel, 0);
      chk("rtf_unused_tk", hif.branch_taken, 1);
      tick();
      set_id(1, 6, 7, 1, 1, 1, 0, 0, 0, 0, 1, 0);
      chk("wb_nofwd", hif.fwd_rt_sel, 0);

      // invalid ID never stalls
      pulse_reset();
      set_id(1, 1, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0);
      tick();
      set_id(0, 8, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("inval_stall", hif.stall, 0);

      // stall counter saturation: lw + dependent branch, 2 stalls per 3
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         set_id(1, 1, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0);
         tick();
         set_id(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0);
         tick();
         tick();
      end
      nop();
      chk("sat_scnt16", hif.stall_cycles, 20);
      chk("sat_scnt4", sif.stall_cycles, 4'hF);

      // flush counter saturation: 19 taken beq $0,$0
      pulse_reset();
      set_id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 19; i++) tick();
      chk("sat_fcnt16", hif.branch_flushes, 19);
      chk("sat_fcnt4", sif.branch_flushes, 4'hF);

      // reset during a load-use stall
      pulse_reset();
      set_id(1, 1, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0);
      tick();
      set_id(1, 8, 1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
      chk("mr_pre_stall", hif.stall, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_async_stall", hif.stall, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mr_post_stall", hif.stall, 0);
      tick();
      chk("mr_scnt", hif.stall_cycles, 0);
      chk("mr_fcnt", hif.branch_flushes, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
